vu_meter: RTL

VU_METER -- requirements
Module: vu_meter

---
 rtl/vu_pkg.sv | 19 +
 rtl/vu_chnl.sv | 45 ++++
 rtl/vu_meter.sv | 56 +++++
 3 files changed

// File: rtl/vu_pkg.sv
// vu_pkg: shared constants, state type and bar helpers for the VU meter
package vu_pkg;
    localparam int LVL_W = 3;
    localparam int DECAY_SH = 3;
    localparam logic [14:0] THR0 = 15'h0200;
    localparam logic [14:0] THR1 = 15'h0800;
    localparam logic [14:0] THR2 = 15'h2000;
    localparam logic [14:0] THR3 = 15'h4000;
    typedef enum logic {SWEEP, RUN} state_t;
    function automatic logic [3:0] thermo(input logic [LVL_W-1:0] lvl);
        for (int i = 0; i < 4; i++) thermo[i] = lvl > LVL_W'(i);
    endfunction
    function automatic logic [3:0] dot(input logic [LVL_W-1:0] lvl);
        return lvl == '0 ? 4'h0 : 4'(4'h1 << (lvl - 1'b1));
    endfunction
    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction
endpackage

// File: rtl/vu_chnl.sv
// vu_chnl: one channel's magnitude, decaying envelope, level and optional peak hold
// Peak hold is built only when VU_PEAK_HOLD_EN is defined; otherwise peak reads 0.
module vu_chnl
    import vu_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             tick,
    input  logic [15:0]      smpl,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] peak
);
    logic [15:0] neg;
    logic [14:0] mag, dec, env;
    always_comb begin
        neg = -smpl;
        // -32768 negates to itself; clamp it to full scale
        mag = !smpl[15] ? smpl[14:0] : neg[15] ? 15'h7FFF : neg[14:0];
        dec = !tick ? env : env == '0 ? '0 : env - (env >> DECAY_SH) - 15'd1;
        level = LVL_W'(env > THR0) + LVL_W'(env > THR1) + LVL_W'(env > THR2) + LVL_W'(env > THR3);
    end
    always_ff @(posedge clk)
        env <= rst ? '0 : (vld && mag > dec) ? mag : dec;
`ifdef VU_PEAK_HOLD_EN
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    logic [TW-1:0] tmr;
    // Reloading while level sits at the peak makes the hold run from the moment the level drops
    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
            tmr  <= '0;
        end else if (level >= peak || tmr == '0) begin
            peak <= level;
            tmr  <= TW'(HOLD_CYCLES - 1);
        end else begin
            tmr  <= tmr - 1'b1;
        end
    end
`else
    assign peak = '0;
`endif
endmodule

// File: rtl/vu_meter.sv
// vu_meter: stereo 8-LED bar meter with power-on sweep, shared decay tick and LED register
// Optional peak-hold dot per channel is enabled by defining VU_PEAK_HOLD_EN.
module vu_meter
    import vu_pkg::*;
#(
    parameter int DECAY_CYCLES = 50000,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int SWEEP_CYCLES = 6250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [15:0] lft_chnnl,
    input  logic [15:0] rght_chnnl,
    output logic [7:0]  LED
);
    localparam int DW = $clog2(DECAY_CYCLES + 1);
    localparam int SW = $clog2(SWEEP_CYCLES + 1);
    state_t state, nxt_state;
    logic [DW-1:0] d_cnt;
    logic [SW-1:0] sw_cnt;
    logic [2:0] step;
    logic tick, sw_end;
    logic [LVL_W-1:0] level_l, level_r, peak_l, peak_r;
    logic [7:0] led_nxt;
    assign tick = d_cnt == DW'(DECAY_CYCLES - 1);
    assign sw_end = sw_cnt == SW'(SWEEP_CYCLES - 1);
    vu_chnl #(.HOLD_CYCLES(HOLD_CYCLES)) u_l (
        .clk(clk), .rst(rst), .vld(vld), .tick(tick), .smpl(lft_chnnl), .level(level_l), .peak(peak_l)
    );
    vu_chnl #(.HOLD_CYCLES(HOLD_CYCLES)) u_r (
        .clk(clk), .rst(rst), .vld(vld), .tick(tick), .smpl(rght_chnnl), .level(level_r), .peak(peak_r)
    );
    always_ff @(posedge clk)
        state <= rst ? SWEEP : nxt_state;
    always_comb
        nxt_state = (state == SWEEP && sw_end && step == 3'd7) ? RUN : state;
    always_comb
        led_nxt = state == SWEEP ? 8'(8'h01 << step)
                : {thermo(level_l) | dot(peak_l), rev4(thermo(level_r) | dot(peak_r))};
    always_ff @(posedge clk) begin
        if (rst) begin
            d_cnt  <= '0;
            sw_cnt <= '0;
            step   <= '0;
            LED    <= '0;
        end else begin
            d_cnt <= tick ? '0 : d_cnt + 1'b1;
            if (state == SWEEP) begin
                sw_cnt <= sw_end ? '0 : sw_cnt + 1'b1;
                step   <= step + 3'(sw_end);
            end
            LED <= led_nxt;
        end
    end
endmodule
